// File: rtl/litedram_tester_pkg.sv
// Shared types and constants for the LiteDRAM port tester.
// LFSR generation is built only when LITEDRAM_PORT_TESTER_LFSR_EN is defined.
package litedram_tester_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] OP_WR_CHK     = 2'd0;
   localparam logic [1:0] OP_WR_ONLY    = 2'd1;
   localparam logic [1:0] OP_CHK_ONLY   = 2'd2;
   localparam logic [1:0] OP_WR_CHK_ALT = 2'd3;

   // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   typedef enum logic {
      PAT_ADDR = 1'b0,
      PAT_LFSR = 1'b1
   } pat_sel_e;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

// File: rtl/litedram_pattern_gen.sv
// Pattern word generator: word k is (seed ^ k) or the k-th LFSR state, replicated to DATA_W.
// The LFSR branch exists only when LITEDRAM_PORT_TESTER_LFSR_EN is defined.
module litedram_pattern_gen
   import litedram_tester_pkg::*;
#(
   parameter int DATA_W = 256
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic              load,
   input  logic              step,
   input  logic [31:0]       seed,
   input  logic              pat_sel,
   output logic [DATA_W-1:0] word
);

   logic [31:0] seed_r;
   logic [31:0] idx;
   logic [31:0] cur;
   logic [31:0] cur_d;

`ifdef LITEDRAM_PORT_TESTER_LFSR_EN
   logic use_lfsr;

   always_ff @(posedge user_clk) begin
      if (user_rst)  use_lfsr <= 1'b0;
      else if (load) use_lfsr <= (pat_sel == PAT_LFSR);
   end
`else
   logic unused_pat_sel;
   assign unused_pat_sel = pat_sel;
`endif

   // cur always holds the word for the current index, so the output is a flop
   always_comb begin
      cur_d = cur;
      if (load) begin
         cur_d = seed;
`ifdef LITEDRAM_PORT_TESTER_LFSR_EN
         if (pat_sel == PAT_LFSR) cur_d = (seed == 32'd0) ? 32'd1 : seed;
`endif
      end else if (step) begin
         cur_d = seed_r ^ (idx + 32'd1);
`ifdef LITEDRAM_PORT_TESTER_LFSR_EN
         if (use_lfsr) cur_d = lfsr_next(cur);
`endif
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         seed_r <= '0;
         idx    <= '0;
         cur    <= '0;
      end else begin
         cur <= cur_d;
         if (load) begin
            seed_r <= seed;
            idx    <= '0;
         end else if (step) begin
            idx <= idx + 32'd1;
         end
      end
   end

   assign word = {(DATA_W/32){cur}};

endmodule

// File: rtl/litedram_port_tester.sv
// Block write/read-back tester for one LiteDRAM native user port (optional LFSR
// patterns via LITEDRAM_PORT_TESTER_LFSR_EN).
//  state    | meaning
//  ST_IDLE  | waiting for start; results and done held
//  ST_WRITE | issuing write commands and write data beats
//  ST_READ  | issuing read commands and checking returned beats
//  ST_DONE  | one-cycle completion, results final
module litedram_port_tester
   import litedram_tester_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 16
) (
   input  logic                  user_clk,
   input  logic                  user_rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic                  pat_sel,
   input  logic [31:0]           seed,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [LEN_W-1:0]      length,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_W-1:0]      err_count,
   output logic [ADDR_W-1:0]     first_err_addr,
   output logic [31:0]           cycles,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic                  cmd_we,
   output logic [ADDR_W-1:0]     cmd_addr,
   output logic                  wdata_valid,
   input  logic                  wdata_ready,
   output logic [DATA_W/8-1:0]   wdata_we,
   output logic [DATA_W-1:0]     wdata_data,
   input  logic                  rdata_valid,
   output logic                  rdata_ready,
   input  logic [DATA_W-1:0]     rdata_data
);

   state_e            state, state_d;
   logic [1:0]        op_r;
   logic [ADDR_W-1:0] base_r, base_d, cmp_addr;
   logic [LEN_W-1:0]  len_r, len_d;
   logic [LEN_W-1:0]  cmd_i, cmd_i_d, wdat_i, wdat_i_d, rd_i;
   logic              start_ok, cmd_fire, wdat_fire, rd_fire;
   logic              cmp_pend, cmp_bad;
   logic [DATA_W-1:0] rd_word;

   assign start_ok  = (state == ST_IDLE) && start;
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign wdat_fire = wdata_valid && wdata_ready;
   assign rd_fire   = rdata_ready && rdata_valid && (rd_i != len_r);
   assign base_d    = start_ok ? base_addr : base_r;
   assign len_d     = start_ok ? length : len_r;
   assign wdata_we  = {(DATA_W/8){wdata_valid}};

   always_ff @(posedge user_clk) begin
      if (user_rst) state <= ST_IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d  = state;
      cmd_i_d  = cmd_i + LEN_W'(cmd_fire);
      wdat_i_d = wdat_i + LEN_W'(wdat_fire);
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               cmd_i_d  = '0;
               wdat_i_d = '0;
               if (length == '0)            state_d = ST_DONE;
               else if (op == OP_CHK_ONLY)  state_d = ST_READ;
               else                         state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (cmd_i_d == len_r && wdat_i_d == len_r) begin
               state_d = (op_r == OP_WR_ONLY) ? ST_DONE : ST_READ;
               cmd_i_d = '0;
            end
         end
         // rd_i reaching len_r leaves the last compare in flight; it lands on the same edge
         ST_READ:  if (cmd_i == len_r && rd_i == len_r) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         op_r           <= '0;
         base_r         <= '0;
         len_r          <= '0;
         cmd_i          <= '0;
         wdat_i         <= '0;
         rd_i           <= '0;
         cmd_valid      <= 1'b0;
         cmd_we         <= 1'b0;
         cmd_addr       <= '0;
         wdata_valid    <= 1'b0;
         rdata_ready    <= 1'b0;
         cmp_pend       <= 1'b0;
         cmp_bad        <= 1'b0;
         cmp_addr       <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         cycles         <= '0;
      end else begin
         cmd_i       <= cmd_i_d;
         wdat_i      <= wdat_i_d;
         cmd_valid   <= (state_d == ST_WRITE || state_d == ST_READ) && (cmd_i_d < len_d);
         cmd_we      <= (state_d == ST_WRITE);
         cmd_addr    <= base_d + ADDR_W'(cmd_i_d);
         wdata_valid <= (state_d == ST_WRITE) && (wdat_i_d < len_d);
         rdata_ready <= (state_d == ST_READ);
         cmp_pend    <= rd_fire;
         cmp_bad     <= (rdata_data != rd_word);
         cmp_addr    <= base_r + ADDR_W'(rd_i);
         if (rd_fire) rd_i <= rd_i + 1'b1;
         if (start_ok) begin
            op_r           <= op;
            base_r         <= base_addr;
            len_r          <= length;
            rd_i           <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            cycles         <= '0;
         end else begin
            if (state == ST_DONE) busy <= 1'b0;
            if (busy && cycles != '1) cycles <= cycles + 1'b1;
            if (cmp_pend && cmp_bad) begin
               if (err_count == '0) first_err_addr <= cmp_addr;
               if (err_count != '1) err_count <= err_count + 1'b1;
            end
         end
         if (state_d == ST_DONE) done <= 1'b1;
      end
   end

   litedram_pattern_gen #(.DATA_W(DATA_W)) u_wr_gen (
      .user_clk (user_clk),
      .user_rst (user_rst),
      .load     (start_ok),
      .step     (wdat_fire),
      .seed     (seed),
      .pat_sel  (pat_sel),
      .word     (wdata_data)
   );

   litedram_pattern_gen #(.DATA_W(DATA_W)) u_rd_gen (
      .user_clk (user_clk),
      .user_rst (user_rst),
      .load     (start_ok),
      .step     (rd_fire),
      .seed     (seed),
      .pat_sel  (pat_sel),
      .word     (rd_word)
   );

endmodule

// File: tb/tb_litedram_port_tester.sv
// Bench for litedram_port_tester: behavioural memory with random backpressure and
// a pattern/error reference model (honours LITEDRAM_PORT_TESTER_LFSR_EN).
`timescale 1ns/1ps
module tb_litedram_port_tester;

   localparam int DATA_W = 256;
   localparam int ADDR_W = 24;
   localparam int LEN_W  = 16;
   localparam int AMASK  = 32'h00FF_FFFF;
`ifdef LITEDRAM_PORT_TESTER_LFSR_EN
   localparam bit LFSR_BUILT = 1'b1;
`else
   localparam bit LFSR_BUILT = 1'b0;
`endif

   logic                user_clk = 1'b0;
   logic                user_rst = 1'b1;
   logic                start = 1'b0;
   logic [1:0]          op = '0;
   logic                pat_sel = 1'b0;
   logic [31:0]         seed = '0;
   logic [ADDR_W-1:0]   base_addr = '0;
   logic [LEN_W-1:0]    length = '0;
   logic                busy, done;
   logic [LEN_W-1:0]    err_count;
   logic [ADDR_W-1:0]   first_err_addr;
   logic [31:0]         cycles;
   logic                cmd_valid, cmd_we;
   logic                cmd_ready = 1'b0;
   logic [ADDR_W-1:0]   cmd_addr;
   logic                wdata_valid;
   logic                wdata_ready = 1'b0;
   logic [DATA_W/8-1:0] wdata_we;
   logic [DATA_W-1:0]   wdata_data;
   logic                rdata_valid = 1'b0;
   logic                rdata_ready;
   logic [DATA_W-1:0]   rdata_data = '0;

   always #5 user_clk = ~user_clk;

   litedram_port_tester #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .user_clk(user_clk), .user_rst(user_rst), .start(start), .op(op), .pat_sel(pat_sel),
      .seed(seed), .base_addr(base_addr), .length(length), .busy(busy), .done(done),
      .err_count(err_count), .first_err_addr(first_err_addr), .cycles(cycles),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata_we(wdata_we),
      .wdata_data(wdata_data), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
      .rdata_data(rdata_data)
   );

   int n_vec = 0;
   int n_bad = 0;
   logic [DATA_W-1:0] mem [int];
   int                wa_q[$];
   logic [DATA_W-1:0] wd_q[$];
   int                rd_pend[$];
   int                wr_log[$];
   int                rd_log[$];
   int beats, we_bad, busy_cnt, rdy_pct;
   int corrupt_addr = -1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] pat_word(input logic p, input logic [31:0] s, input int k);
      logic [31:0] v;
      if (p && LFSR_BUILT) begin
         v = (s == 32'd0) ? 32'd1 : s;
         for (int i = 0; i < k; i++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
      end else begin
         v = s ^ 32'(k);
      end
      return {(DATA_W/32){v}};
   endfunction

   function automatic logic [DATA_W-1:0] mem_rd(input int a);
      logic [DATA_W-1:0] w;
      w = mem.exists(a) ? mem[a] : '0;
      if (a == corrupt_addr) w[0] = ~w[0];
      return w;
   endfunction

   // One clock: memory reacts at negedge, DUT outputs are sampled 1ns after posedge
   task automatic tick();
      int a;
      @(negedge user_clk);
      cmd_ready   = ($urandom_range(99) < rdy_pct);
      wdata_ready = ($urandom_range(99) < rdy_pct);
      rdata_valid = 1'b0;
      rdata_data  = {(DATA_W/32){$urandom}};
      if (user_rst) begin
         wa_q.delete(); wd_q.delete(); rd_pend.delete();
      end else begin
         if (rd_pend.size() > 0 && $urandom_range(99) < rdy_pct) begin
            rdata_valid = 1'b1;
            rdata_data  = mem_rd(rd_pend[0]);
         end
         if (cmd_valid && cmd_ready) begin
            if (cmd_we) begin
               wa_q.push_back(int'(cmd_addr));
               wr_log.push_back(int'(cmd_addr));
            end else begin
               rd_pend.push_back(int'(cmd_addr));
               rd_log.push_back(int'(cmd_addr));
            end
         end
         if (wdata_valid && wdata_ready) begin
            wd_q.push_back(wdata_data);
            if (wdata_we != '1) we_bad++;
         end
         if (rdata_valid && rdata_ready) begin
            a = rd_pend.pop_front();
            beats++;
         end
         while (wa_q.size() > 0 && wd_q.size() > 0) begin
            a = wa_q.pop_front();
            mem[a] = wd_q.pop_front();
         end
      end
      @(posedge user_clk);
      #1;
      if (busy) busy_cnt++;
   endtask

   task automatic run(input logic [1:0] o, input logic p, input logic [31:0] s,
                      input int b, input int n, input int pct, input bit poke);
      int wr_n, rd_n, bad, exp_err, exp_first;
      rdy_pct = pct;
      wr_log.delete(); rd_log.delete();
      beats = 0; we_bad = 0; busy_cnt = 0;
      op = o; pat_sel = p; seed = s; base_addr = ADDR_W'(b); length = LEN_W'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_rise", busy, 1);
      chk("first_cmd", cmd_valid, (n != 0));
      chk("done_at_start", done, (n == 0));
      for (int lim = 0; lim < 3000 && !done; lim++) begin
         if (poke && lim == 2) begin
            start = 1'b1; op = 2'd1; base_addr = 24'h000500; length = 3; seed = ~s;
         end
         tick();
         start = 1'b0;
      end
      chk("done_set", done, 1);
      tick();
      chk("busy_fall", busy, 0);
      chk("done_hold", done, 1);
      chk("cycles", cycles, busy_cnt);

      wr_n = (n != 0 && o != 2'd2) ? n : 0;
      rd_n = (n != 0 && o != 2'd1) ? n : 0;
      chk("wr_cmds", wr_log.size(), wr_n);
      chk("rd_cmds", rd_log.size(), rd_n);
      chk("rd_beats", beats, rd_n);
      chk("wr_unpaired", wa_q.size() + wd_q.size(), 0);
      chk("wdata_we", we_bad, 0);
      bad = 0;
      for (int k = 0; k < wr_n && k < wr_log.size(); k++) begin
         if (wr_log[k] != ((b + k) & AMASK)) bad++;
         if (!mem.exists((b + k) & AMASK) || mem[(b + k) & AMASK] != pat_word(p, s, k)) bad++;
      end
      chk("wr_seq_data", bad, 0);
      bad = 0;
      for (int k = 0; k < rd_n && k < rd_log.size(); k++)
         if (rd_log[k] != ((b + k) & AMASK)) bad++;
      chk("rd_seq", bad, 0);
      exp_err = 0; exp_first = 0;
      for (int k = 0; k < rd_n; k++) begin
         if (mem_rd((b + k) & AMASK) != pat_word(p, s, k)) begin
            if (exp_err == 0) exp_first = (b + k) & AMASK;
            exp_err++;
         end
      end
      chk("err_count", err_count, exp_err);
      chk("first_err_addr", first_err_addr, exp_first);
   endtask

   initial begin
      int o, n, b;
      rdy_pct = 100;
      repeat (3) tick();
      user_rst = 1'b0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_count, 0);
      chk("rst_first", first_err_addr, 0);
      chk("rst_cycles", cycles, 0);
      chk("rst_valids", {cmd_valid, cmd_we, wdata_valid, rdata_ready}, 0);
      chk("rst_addr", cmd_addr, 0);
      chk("rst_wdata_zero", (wdata_data == '0), 1);
      chk("rst_we", wdata_we, 0);

      run(2'd0, 1'b0, 32'h0, 32'h10, 8, 100, 1'b0);
      chk("cycles_full_rate", cycles, 19);

      run(2'd0, 1'b0, 32'h1234_5678, 32'hFF_FFFE, 4, 50, 1'b0);

      run(2'd1, 1'b1, 32'h0000_ACE1, 32'h200, 12, 70, 1'b0);
      corrupt_addr = 32'h205;
      run(2'd2, 1'b1, 32'h0000_ACE1, 32'h200, 12, 70, 1'b0);
      chk("corrupt_err", err_count, 1);
      chk("corrupt_first", first_err_addr, 24'h000205);
      corrupt_addr = -1;

      run(2'd0, 1'b0, 32'h5, 32'h40, 0, 100, 1'b0);
      chk("cycles_zero_len", cycles, 1);

      run(2'd3, 1'b0, 32'hA5A5_0000, 32'h300, 8, 100, 1'b1);

      rdy_pct = 100;
      op = 2'd0; pat_sel = 1'b0; seed = 32'h77; base_addr = 24'h000800; length = 16;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("mid_in_write", cmd_valid && cmd_we, 1);
      user_rst = 1'b1;
      tick();
      chk("mid_rst_valids", {cmd_valid, wdata_valid, rdata_ready}, 0);
      chk("mid_rst_busy", busy, 0);
      user_rst = 1'b0;
      tick();
      run(2'd0, 1'b1, 32'h77, 32'h800, 16, 60, 1'b0);

      for (int t = 0; t < 6; t++) begin
         o = $urandom_range(3);
         n = $urandom_range(24, 1);
         b = $urandom_range(32'hFF_FFFF);
         corrupt_addr = ($urandom_range(1) == 1) ? ((b + $urandom_range(n - 1)) & AMASK) : -1;
         run(o[1:0], 1'($urandom_range(1)), $urandom, b, n, $urandom_range(100, 30), 1'b0);
      end
      corrupt_addr = -1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
